// File: rtl/cpu_clk_pkg.sv
// Shared constants and FSM encoding for the MIPS clock-enable scheduler.
package cpu_clk_pkg;
    localparam int DIV_W_DEF       = 16;
    localparam int DIV_DEFAULT_10K = 5000;

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } state_t;
endpackage

// File: rtl/cpu_clk_sched_in_debounce.sv
// Two-flop synchronizer followed by a stable-for-DEB_CYCLES debouncer.
module in_debounce #(
    parameter int DEB_CYCLES = 500000,
    parameter int DEB_W      = 20
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_db
);
    localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEB_CYCLES - 1);

    logic             r_meta;
    logic             r_sync;
    logic             r_db;
    logic [DEB_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_db   <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            // Any return to the accepted level restarts the stability window.
            if (r_sync == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_db  <= r_sync;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + DEB_W'(1);
            end
        end
    end

    assign o_db = r_db;
endmodule

// File: rtl/cpu_clk_sched.sv
// Run/halt/single-step scheduler: issues a one-cycle cpu_en strobe every Ne
// board clocks while running, or one strobe per debounced step press.
module cpu_clk_sched
    import cpu_clk_pkg::*;
#(
    parameter int DIV_DEFAULT = DIV_DEFAULT_10K,
    parameter int DIV_W       = DIV_W_DEF,
    parameter int DEB_CYCLES  = 500000,
    parameter int DEB_W       = 20
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_run_sw,
    input  logic             i_step_btn,
    input  logic             i_div_load,
    input  logic [DIV_W-1:0] i_div_val,
    output logic             o_cpu_en,
    output logic             o_running,
    output logic [31:0]      o_en_count
);
    logic             w_run_db;
    logic             w_step_db;
    logic             w_step_req;
    logic             r_step_db_q;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] w_cnt_nxt;
    logic [DIV_W-1:0] w_ne_last;
    logic             w_en_nxt;
    logic             r_en;
    logic             r_running;
    logic [31:0]      r_en_count;

    in_debounce #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_run_db (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_async (i_run_sw),
        .o_db    (w_run_db)
    );

    in_debounce #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_step_db (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_async (i_step_btn),
        .o_db    (w_step_db)
    );

    assign w_step_req = w_step_db & ~r_step_db_q;
    // A ratio of zero behaves as one, so the last count is never below zero.
    assign w_ne_last  = (r_div == '0) ? '0 : r_div - DIV_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_en_nxt    = 1'b0;
        case (r_state)
            ST_HALT: begin
                if (w_run_db) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = '0;
                end else if (w_step_req) begin
                    w_state_nxt = ST_STEP;
                    w_en_nxt    = 1'b1;
                end
            end
            ST_RUN: begin
                if (!w_run_db) begin
                    w_state_nxt = ST_HALT;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == w_ne_last) begin
                    w_cnt_nxt = '0;
                    w_en_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + DIV_W'(1);
                end
            end
            default: w_state_nxt = ST_HALT;
        endcase
        if (i_div_load) w_cnt_nxt = '0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_HALT;
            r_div       <= DIV_W'(DIV_DEFAULT);
            r_cnt       <= '0;
            r_en        <= 1'b0;
            r_running   <= 1'b0;
            r_en_count  <= '0;
            r_step_db_q <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_en        <= w_en_nxt;
            r_running   <= (w_state_nxt == ST_RUN);
            r_en_count  <= r_en_count + 32'(r_en);
            r_step_db_q <= w_step_db;
            if (i_div_load) r_div <= i_div_val;
        end
    end

    assign o_cpu_en   = r_en;
    assign o_running  = r_running;
    assign o_en_count = r_en_count;
endmodule

// File: tb/tb_cpu_clk_sched.sv
// Directed bench for cpu_clk_sched with DEB_CYCLES=4 and DIV_DEFAULT=5.
module tb_cpu_clk_sched;
    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        run_sw   = 1'b0;
    logic        step_btn = 1'b0;
    logic        div_load = 1'b0;
    logic [15:0] div_val  = '0;
    logic        cpu_en;
    logic        running;
    logic [31:0] en_count;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    cpu_clk_sched #(.DIV_DEFAULT(5), .DIV_W(16), .DEB_CYCLES(4), .DEB_W(20)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_run_sw   (run_sw),
        .i_step_btn (step_btn),
        .i_div_load (div_load),
        .i_div_val  (div_val),
        .o_cpu_en   (cpu_en),
        .o_running  (running),
        .o_en_count (en_count)
    );

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        // 1. reset and idle
        tick(3);
        chk("rst_en", 32'(cpu_en), 0);
        chk("rst_running", 32'(running), 0);
        chk("rst_count", en_count, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            chk("idle", 32'({cpu_en, running}), 0);
        end
        chk("idle_count", en_count, 0);

        // 2. free-run at Ne=5; db rises 6 edges after the switch, FSM one later
        run_sw = 1'b1;
        tick(5);
        chk("run_early", 32'(running), 0);
        tick(2);
        chk("run_entered", 32'(running), 1);
        for (int i = 1; i <= 35; i++) begin
            tick();
            if (i == 20) run_sw = 1'b0;
            chk("run_strobe", 32'(cpu_en), 32'((i <= 26) && (i % 5 == 0)));
            if (i == 21) chk("run_count4", en_count, 4);
        end
        chk("halt_running", 32'(running), 0);
        chk("halt_count", en_count, 5);

        // 3. held step button gives exactly one strobe per press
        step_btn = 1'b1;
        for (int i = 1; i <= 50; i++) begin
            tick();
            chk("step1", 32'(cpu_en), 32'(i == 7));
        end
        chk("step1_count", en_count, 6);
        chk("step1_halt", 32'(running), 0);
        step_btn = 1'b0;
        tick(10);
        step_btn = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            chk("step2", 32'(cpu_en), 32'(i == 7));
        end
        chk("step2_count", en_count, 7);
        step_btn = 1'b0;
        tick(10);

        // 4. 3-cycle glitches on both inputs are rejected
        step_btn = 1'b1;
        tick(3);
        step_btn = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("glitch_step", 32'({cpu_en, running}), 0);
        end
        run_sw = 1'b1;
        tick(3);
        run_sw = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("glitch_run", 32'({cpu_en, running}), 0);
        end
        chk("glitch_count", en_count, 7);

        // 5. divide reload while running
        run_sw = 1'b1;
        tick(7);
        chk("run2_entered", 32'(running), 1);
        tick(2);
        div_load = 1'b1;
        div_val  = 16'd2;
        tick();
        div_load = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk("div2_strobe", 32'(cpu_en), 32'(i % 2 == 0));
        end
        chk("div2_count", en_count, 11);
        div_load = 1'b1;
        div_val  = 16'd0;
        tick();
        div_load = 1'b0;
        chk("div0_count_a", en_count, 12);
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("div0_strobe", 32'(cpu_en), 1);
        end
        chk("div0_count_b", en_count, 19);
        div_load = 1'b1;
        div_val  = 16'd1;
        tick();
        div_load = 1'b0;
        chk("div1_load", 32'(cpu_en), 1);
        chk("div1_count_a", en_count, 20);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("div1_strobe", 32'(cpu_en), 1);
        end
        chk("div1_count_b", en_count, 24);

        // 6. async reset between strobes, then simultaneous run + step
        div_load = 1'b1;
        div_val  = 16'd4;
        tick();
        div_load = 1'b0;
        tick(2);
        chk("pre_rst_en", 32'(cpu_en), 0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_en", 32'(cpu_en), 0);
        chk("midrst_running", 32'(running), 0);
        chk("midrst_count", en_count, 0);
        run_sw   = 1'b0;
        step_btn = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        run_sw   = 1'b1;
        step_btn = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            chk("both_strobe", 32'(cpu_en), 32'(i == 12));
            if (i >= 7) chk("both_running", 32'(running), 1);
        end
        tick();
        chk("both_count", en_count, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
